control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have parameter CW_W, default 31, meaning control word width.
REQ-002 SHALL have parameter DATA_W, default 64, meaning immediate/K width.
REQ-003 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports cmd_valid  input  1, and cmd_ready  output  1  command handshake.
REQ-006 SHALL have ports cmd_op  input  3, cmd_rd/cmd_rn/cmd_rm  input  5 each, cmd_imm  input  DATA_W, and cmd_setf  input  1  command fields.
REQ-007 SHALL have port status  input  5  datapath status flags.
REQ-008 SHALL have ports controlWord  output  CW_W, K  output  DATA_W, halted  output  1, and flags  output  5.

Function
REQ-009 controlWord bit layout SHALL be {PS[1:0], DA[4:0], SA[4:0], SB[4:0], FS[4:0], regW, ramW, EN_MEM, EN_ALU, EN_B, EN_PC, selB, PCsel, SL}, MSB first; selB=1 selects K.
REQ-010 A command SHALL be accepted on an edge where cmd_valid and cmd_ready are both high; its first word SHALL be registered onto controlWord/K at that edge (latency 1 edge).
REQ-011 An edge without acceptance that does not emit a LDUR phase-2 word SHALL load NOP: PS=00, DA=SA=SB=31, FS=00100, all enables/writes 0, K=0.
REQ-012 Opcodes SHALL be: 000 NOP; 001 ADDI (Rd<=Rn+imm); 010 ADD (Rd<=Rn+Rm); 011 XOR (Rd<=Rn^Rm); 100 LSLI (Rd<=Rn<<imm); 101 STUR (M[Rn+imm]<=Rd); 110 LDUR (Rd<=M[Rn+imm]); 111 HALT.
REQ-013 ALU ops SHALL drive DA=rd, SA=rn, SB=rm, EN_ALU=1, regW=1, PS=01; ADDI/LSLI SHALL set selB=1 and K=imm; ADD/XOR SHALL set selB=0 and K=0.
REQ-014 STUR SHALL emit one word: SA=rn, SB=rd, FS=ADD, selB=1, K=imm, ramW=1, regW=0, PS=01.
REQ-015 LDUR SHALL emit two consecutive words: phase 1 is SA=rn, FS=ADD, selB=1, K=imm, EN_ALU=1, regW=0, PS=00; phase 2 is identical except EN_ALU=0, EN_MEM=1, regW=1, DA=rd, PS=01.
REQ-016 The FSM SHALL have states IDLE, LOAD_WB, and HALT_ST: IDLE goes to LOAD_WB on LDUR accept and to HALT_ST on HALT accept; LOAD_WB always returns to IDLE; HALT_ST is left only by reset.
REQ-017 cmd_ready SHALL be 1 only in IDLE, so back-to-back single-word commands issue one word per cycle.
REQ-018 Any command with rd=31 that writes a register SHALL force regW=0.
REQ-019 An accepted NOP opcode SHALL emit the NOP word with PS=01.
REQ-020 halted SHALL be 1 exactly in HALT_ST, during which controlWord SHALL be NOP with PS=00.

Reset
REQ-021 While reset=0, the FSM SHALL be in IDLE and SHALL output controlWord=NOP (PS=00), K=0, cmd_ready=1 (after release), halted=0, and flags=0, independent of clock.
REQ-022 Reset asserted during LOAD_WB SHALL abandon phase 2; no regW pulse SHALL follow.

Configuration
REQ-023 With CTRL_SEQ_FLAGS_EN defined, flags SHALL capture status on the edge after an emitted ALU word whose command had cmd_setf=1, and SHALL hold otherwise.
REQ-024 Without CTRL_SEQ_FLAGS_EN, flags SHALL be constant 0 and cmd_setf/status SHALL be ignored.

Structure
REQ-025 The package ctrl_seq_pkg SHALL hold the opcode enum, the FSM state enum, FS constants (PASSB=00100, ADD=01000, XOR=01100, LSL=10000), the PS constants, and the NOP word constant.
REQ-026 Sub-module cw_encode SHALL combinationally map a command plus phase to {controlWord, K}; the FSM and registers SHALL live in control_sequencer.

Verification
REQ-027 Reset, then ADDI rd=5 rn=31 imm=24 -> next edge controlWord=01_00101_11111_xxxxx_01000, regW=1, selB=1, K=24.
REQ-028 ADD 1,5,7 then XOR 30,1,5 on consecutive cycles -> cmd_ready stays 1 and two words issue on consecutive edges, then NOP.
REQ-029 LDUR rd=0 rn=7 imm=0 -> phase 1 (PS=00, regW=0), then phase 2 (EN_MEM=1, regW=1, DA=0), with cmd_ready=0 for exactly one cycle.
REQ-030 ADDI rd=31 imm=4 -> regW=0, PS=01.
REQ-031 LDUR accepted then reset pulsed in the LOAD_WB cycle -> NOP with PS=00, no regW=1 word, cmd_ready=1.
REQ-032 HALT -> halted=1 and cmd_ready=0 for 10 cycles despite cmd_valid=1; with CTRL_SEQ_FLAGS_EN, ADD with setf=1 and status=5'b01001 -> flags=01001.

Source files
------------

// File: rtl/ctrl_seq_pkg.sv
// Shared opcode/state enums, control-word layout and constants for control_sequencer.
package ctrl_seq_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_ADDI = 3'b001,
        OP_ADD  = 3'b010,
        OP_XOR  = 3'b011,
        OP_LSLI = 3'b100,
        OP_STUR = 3'b101,
        OP_LDUR = 3'b110,
        OP_HALT = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD_WB = 2'd1,
        HALT_ST = 2'd2
    } state_e;

    localparam logic [4:0] FS_PASSB = 5'b00100;
    localparam logic [4:0] FS_ADD   = 5'b01000;
    localparam logic [4:0] FS_XOR   = 5'b01100;
    localparam logic [4:0] FS_LSL   = 5'b10000;

    localparam logic [1:0] PS_HOLD  = 2'b00;
    localparam logic [1:0] PS_INC   = 2'b01;

    localparam logic [4:0] REG_ZR   = 5'd31;

    // Field order is the bit order of controlWord, MSB first.
    typedef struct packed {
        logic [1:0] ps;
        logic [4:0] da;
        logic [4:0] sa;
        logic [4:0] sb;
        logic [4:0] fs;
        logic       reg_w;
        logic       ram_w;
        logic       en_mem;
        logic       en_alu;
        logic       en_b;
        logic       en_pc;
        logic       sel_b;
        logic       pc_sel;
        logic       sl;
    } cw_t;

    localparam cw_t CW_NOP = '{
        ps: PS_HOLD, da: REG_ZR, sa: REG_ZR, sb: REG_ZR, fs: FS_PASSB,
        reg_w: 1'b0, ram_w: 1'b0, en_mem: 1'b0, en_alu: 1'b0, en_b: 1'b0,
        en_pc: 1'b0, sel_b: 1'b0, pc_sel: 1'b0, sl: 1'b0
    };

    function automatic logic is_alu_op(input logic [2:0] op);
        return (op == OP_ADDI) || (op == OP_ADD) || (op == OP_XOR) || (op == OP_LSLI);
    endfunction

endpackage

// File: rtl/control_sequencer_cw_encode.sv
// cw_encode: combinational map from a command (or LDUR write-back phase) to {controlWord, K}.
module cw_encode
    import ctrl_seq_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic              i_issue,
    input  logic              i_phase2,
    input  logic [2:0]        i_op,
    input  logic [4:0]        i_rd,
    input  logic [4:0]        i_rn,
    input  logic [4:0]        i_rm,
    input  logic [DATA_W-1:0] i_imm,
    output cw_t               o_cw,
    output logic [DATA_W-1:0] o_k
);

    logic w_rd_live;
    assign w_rd_live = (i_rd != REG_ZR);

    always_comb begin
        o_cw = CW_NOP;
        o_k  = '0;
        if (i_phase2) begin
            o_cw.ps     = PS_INC;
            o_cw.da     = i_rd;
            o_cw.sa     = i_rn;
            o_cw.fs     = FS_ADD;
            o_cw.sel_b  = 1'b1;
            o_cw.en_mem = 1'b1;
            o_cw.reg_w  = w_rd_live;
            o_k         = i_imm;
        end else if (i_issue) begin
            case (i_op)
                OP_NOP: o_cw.ps = PS_INC;
                OP_ADDI, OP_ADD, OP_XOR, OP_LSLI: begin
                    o_cw.ps     = PS_INC;
                    o_cw.da     = i_rd;
                    o_cw.sa     = i_rn;
                    o_cw.sb     = i_rm;
                    o_cw.en_alu = 1'b1;
                    o_cw.reg_w  = w_rd_live;
                    o_cw.fs     = (i_op == OP_XOR)  ? FS_XOR :
                                  (i_op == OP_LSLI) ? FS_LSL : FS_ADD;
                    if ((i_op == OP_ADDI) || (i_op == OP_LSLI)) begin
                        o_cw.sel_b = 1'b1;
                        o_k        = i_imm;
                    end
                end
                OP_STUR: begin
                    o_cw.ps    = PS_INC;
                    o_cw.sa    = i_rn;
                    o_cw.sb    = i_rd;
                    o_cw.fs    = FS_ADD;
                    o_cw.sel_b = 1'b1;
                    o_cw.ram_w = 1'b1;
                    o_k        = i_imm;
                end
                // Phase 1 only forms the address; PC holds until write-back.
                OP_LDUR: begin
                    o_cw.sa     = i_rn;
                    o_cw.fs     = FS_ADD;
                    o_cw.sel_b  = 1'b1;
                    o_cw.en_alu = 1'b1;
                    o_k         = i_imm;
                end
                default: o_cw = CW_NOP;
            endcase
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: command-to-control-word sequencer with LDUR two-phase issue and HALT.
// Optional status flag capture is enabled by defining CTRL_SEQ_FLAGS_EN.
module control_sequencer
    import ctrl_seq_pkg::*;
#(
    parameter int CW_W   = 31,
    parameter int DATA_W = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [4:0]        cmd_rd,
    input  logic [4:0]        cmd_rn,
    input  logic [4:0]        cmd_rm,
    input  logic [DATA_W-1:0] cmd_imm,
    input  logic              cmd_setf,
    input  logic [4:0]        status,
    output logic [CW_W-1:0]   controlWord,
    output logic [DATA_W-1:0] K,
    output logic              halted,
    output logic [4:0]        flags
);

    state_e            r_state;
    state_e            w_next;
    logic              w_accept;
    logic              w_phase2;
    logic [4:0]        r_ld_rd;
    logic [4:0]        r_ld_rn;
    logic [DATA_W-1:0] r_ld_imm;
    cw_t               w_cw;
    logic [DATA_W-1:0] w_k;
    cw_t               r_cw;
    logic [DATA_W-1:0] r_k;

    assign w_accept = cmd_valid && cmd_ready;
    assign w_phase2 = (r_state == LOAD_WB);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        cmd_ready = 1'b0;
        halted    = 1'b0;
        case (r_state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (w_accept && (cmd_op == OP_LDUR)) w_next = LOAD_WB;
                else if (w_accept && (cmd_op == OP_HALT)) w_next = HALT_ST;
            end
            LOAD_WB: w_next = IDLE;
            HALT_ST: halted = 1'b1;
            default: w_next = IDLE;
        endcase
    end

    // LDUR operands are held for the write-back word; plain data, no reset needed.
    always_ff @(posedge clock) begin
        if (w_accept) begin
            r_ld_rd  <= cmd_rd;
            r_ld_rn  <= cmd_rn;
            r_ld_imm <= cmd_imm;
        end
    end

    cw_encode #(
        .DATA_W (DATA_W)
    ) u_cw_encode (
        .i_issue  (w_accept),
        .i_phase2 (w_phase2),
        .i_op     (cmd_op),
        .i_rd     (w_phase2 ? r_ld_rd  : cmd_rd),
        .i_rn     (w_phase2 ? r_ld_rn  : cmd_rn),
        .i_rm     (cmd_rm),
        .i_imm    (w_phase2 ? r_ld_imm : cmd_imm),
        .o_cw     (w_cw),
        .o_k      (w_k)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cw <= CW_NOP;
            r_k  <= '0;
        end else begin
            r_cw <= w_cw;
            r_k  <= w_k;
        end
    end

    assign controlWord = CW_W'(r_cw);
    assign K           = r_k;

`ifdef CTRL_SEQ_FLAGS_EN
    logic       r_setf_pend;
    logic [4:0] r_flags;

    // Status reflects the ALU word one cycle after it is issued.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_setf_pend <= 1'b0;
            r_flags     <= '0;
        end else begin
            r_setf_pend <= w_accept && cmd_setf && is_alu_op(cmd_op);
            if (r_setf_pend) r_flags <= status;
        end
    end

    assign flags = r_flags;
`else
    logic w_unused_flag_inputs;
    assign w_unused_flag_inputs = ^{cmd_setf, status};
    assign flags = '0;
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer using an expected-word scoreboard.
module tb_control_sequencer;

    localparam int CW_W   = 31;
    localparam int DATA_W = 64;

    localparam logic [2:0] C_NOP = 3'b000, C_ADDI = 3'b001, C_ADD = 3'b010, C_XOR = 3'b011;
    localparam logic [2:0] C_LSLI = 3'b100, C_STUR = 3'b101, C_LDUR = 3'b110, C_HALT = 3'b111;
    localparam logic [4:0] F_PASSB = 5'b00100, F_ADD = 5'b01000, F_XOR = 5'b01100, F_LSL = 5'b10000;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [2:0]        cmd_op = '0;
    logic [4:0]        cmd_rd = '0, cmd_rn = '0, cmd_rm = '0;
    logic [DATA_W-1:0] cmd_imm = '0;
    logic              cmd_setf = 1'b0;
    logic [4:0]        status = '0;
    logic [CW_W-1:0]   controlWord;
    logic [DATA_W-1:0] K;
    logic              halted;
    logic [4:0]        flags;

    control_sequencer #(.CW_W(CW_W), .DATA_W(DATA_W)) dut (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rn(cmd_rn), .cmd_rm(cmd_rm),
        .cmd_imm(cmd_imm), .cmd_setf(cmd_setf), .status(status),
        .controlWord(controlWord), .K(K), .halted(halted), .flags(flags)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic              v;
        logic [2:0]        op;
        logic [4:0]        rd, rn, rm;
        logic [DATA_W-1:0] imm;
        logic              setf;
        logic [4:0]        st;
    } stim_t;

    typedef struct packed {
        logic [CW_W-1:0]   cw;
        logic [DATA_W-1:0] k;
        logic              rdy;
        logic              hlt;
        logic [4:0]        fl;
    } exp_t;

    stim_t sq[$];
    exp_t  q[$];
    int    checks = 0;
    int    failures = 0;
    logic [4:0] exp_flags = '0;

    function automatic logic [CW_W-1:0] mkcw(input logic [1:0] ps, input logic [4:0] da, sa, sb, fs,
                                             input logic regw, ramw, enmem, enalu, selb);
        return {ps, da, sa, sb, fs, regw, ramw, enmem, enalu, 1'b0, 1'b0, selb, 1'b0, 1'b0};
    endfunction

    function automatic logic [CW_W-1:0] nopw(input logic [1:0] ps);
        return mkcw(ps, 5'd31, 5'd31, 5'd31, F_PASSB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic stim_t mks(input logic v, input logic [2:0] op, input logic [4:0] rd, rn, rm,
                                  input logic [DATA_W-1:0] imm, input logic setf, input logic [4:0] st);
        stim_t s;
        s = '{v: v, op: op, rd: rd, rn: rn, rm: rm, imm: imm, setf: setf, st: st};
        return s;
    endfunction

    function automatic exp_t mke(input logic [CW_W-1:0] cw, input logic [DATA_W-1:0] k,
                                 input logic rdy, input logic hlt, input logic [4:0] fl);
        exp_t e;
        e = '{cw: cw, k: k, rdy: rdy, hlt: hlt, fl: fl};
        return e;
    endfunction

    task automatic apply(input stim_t s);
        cmd_valid = s.v;  cmd_op = s.op;  cmd_rd = s.rd;  cmd_rn = s.rn;  cmd_rm = s.rm;
        cmd_imm = s.imm;  cmd_setf = s.setf;  status = s.st;
    endtask

    task automatic push(input stim_t s, input exp_t e);
        sq.push_back(s);
        q.push_back(e);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        apply(mks(1'b0, C_NOP, 0, 0, 0, 0, 1'b0, 5'b0));
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (controlWord !== nopw(2'b00)) begin failures++; $display("FAIL reset_cw got=%h want=%h", controlWord, nopw(2'b00)); end
        checks++;
        if (K !== '0) begin failures++; $display("FAIL reset_k got=%0d want=0", K); end
        checks++;
        if ({cmd_ready, halted} !== 2'b10) begin failures++; $display("FAIL reset_rdy_hlt got=%b want=10", {cmd_ready, halted}); end
        checks++;
        if (flags !== 5'b0) begin failures++; $display("FAIL reset_flags got=%b want=00000", flags); end
        reset = 1'b1;
    endtask

    task automatic test_addi();
        push(mks(1'b1, C_ADDI, 5, 31, 0, 24, 1'b0, 5'b0),
             mke(mkcw(2'b01, 5, 31, 0, F_ADD, 1, 0, 0, 1, 1), 24, 1, 0, exp_flags));
        push(mks(1'b0, C_NOP, 0, 0, 0, 0, 1'b0, 5'b0), mke(nopw(2'b00), 0, 1, 0, exp_flags));
        for (int i = 0; sq.size() > 0; i++) begin
            exp_t e;
            apply(sq.pop_front());
            @(posedge clock); #1;
            e = q.pop_front();
            checks++;
            if ({controlWord, K, cmd_ready, halted, flags} !== {e.cw, e.k, e.rdy, e.hlt, e.fl}) begin
                failures++;
                $display("FAIL addi[%0d] got cw=%h k=%0d rdy=%b hlt=%b fl=%b want cw=%h k=%0d rdy=%b hlt=%b fl=%b",
                         i, controlWord, K, cmd_ready, halted, flags, e.cw, e.k, e.rdy, e.hlt, e.fl);
            end
        end
    endtask

    task automatic test_back_to_back();
        push(mks(1'b1, C_ADD, 1, 5, 7, 99, 1'b0, 5'b0),
             mke(mkcw(2'b01, 1, 5, 7, F_ADD, 1, 0, 0, 1, 0), 0, 1, 0, exp_flags));
        push(mks(1'b1, C_XOR, 30, 1, 5, 0, 1'b0, 5'b0),
             mke(mkcw(2'b01, 30, 1, 5, F_XOR, 1, 0, 0, 1, 0), 0, 1, 0, exp_flags));
        push(mks(1'b1, C_LSLI, 2, 2, 9, 3, 1'b0, 5'b0),
             mke(mkcw(2'b01, 2, 2, 9, F_LSL, 1, 0, 0, 1, 1), 3, 1, 0, exp_flags));
        push(mks(1'b0, C_ADD, 1, 5, 7, 0, 1'b0, 5'b0), mke(nopw(2'b00), 0, 1, 0, exp_flags));
        for (int i = 0; sq.size() > 0; i++) begin
            exp_t e;
            apply(sq.pop_front());
            @(posedge clock); #1;
            e = q.pop_front();
            checks++;
            if ({controlWord, K, cmd_ready, halted, flags} !== {e.cw, e.k, e.rdy, e.hlt, e.fl}) begin
                failures++;
                $display("FAIL back_to_back[%0d] got cw=%h k=%0d rdy=%b hlt=%b fl=%b want cw=%h k=%0d rdy=%b hlt=%b fl=%b",
                         i, controlWord, K, cmd_ready, halted, flags, e.cw, e.k, e.rdy, e.hlt, e.fl);
            end
        end
    endtask

    task automatic test_ldur();
        push(mks(1'b1, C_LDUR, 0, 7, 3, 0, 1'b0, 5'b0),
             mke(mkcw(2'b00, 31, 7, 31, F_ADD, 0, 0, 0, 1, 1), 0, 0, 0, exp_flags));
        // Held ADD during write-back must be ignored.
        push(mks(1'b1, C_ADD, 9, 9, 9, 0, 1'b0, 5'b0),
             mke(mkcw(2'b01, 0, 7, 31, F_ADD, 1, 0, 1, 0, 1), 0, 1, 0, exp_flags));
        push(mks(1'b1, C_LDUR, 31, 4, 0, 16, 1'b0, 5'b0),
             mke(mkcw(2'b00, 31, 4, 31, F_ADD, 0, 0, 0, 1, 1), 16, 0, 0, exp_flags));
        push(mks(1'b0, C_NOP, 0, 0, 0, 0, 1'b0, 5'b0),
             mke(mkcw(2'b01, 31, 4, 31, F_ADD, 0, 0, 1, 0, 1), 16, 1, 0, exp_flags));
        push(mks(1'b0, C_NOP, 0, 0, 0, 0, 1'b0, 5'b0), mke(nopw(2'b00), 0, 1, 0, exp_flags));
        for (int i = 0; sq.size() > 0; i++) begin
            exp_t e;
            apply(sq.pop_front());
            @(posedge clock); #1;
            e = q.pop_front();
            checks++;
            if ({controlWord, K, cmd_ready, halted, flags} !== {e.cw, e.k, e.rdy, e.hlt, e.fl}) begin
                failures++;
                $display("FAIL ldur[%0d] got cw=%h k=%0d rdy=%b hlt=%b fl=%b want cw=%h k=%0d rdy=%b hlt=%b fl=%b",
                         i, controlWord, K, cmd_ready, halted, flags, e.cw, e.k, e.rdy, e.hlt, e.fl);
            end
        end
    endtask

    task automatic test_misc_ops();
        push(mks(1'b1, C_ADDI, 31, 2, 0, 4, 1'b0, 5'b0),
             mke(mkcw(2'b01, 31, 2, 0, F_ADD, 0, 0, 0, 1, 1), 4, 1, 0, exp_flags));
        push(mks(1'b1, C_STUR, 3, 4, 6, 8, 1'b0, 5'b0),
             mke(mkcw(2'b01, 31, 4, 3, F_ADD, 0, 1, 0, 0, 1), 8, 1, 0, exp_flags));
        push(mks(1'b1, C_NOP, 5, 6, 7, 77, 1'b0, 5'b0), mke(nopw(2'b01), 0, 1, 0, exp_flags));
        push(mks(1'b1, C_XOR, 31, 8, 9, 0, 1'b0, 5'b0),
             mke(mkcw(2'b01, 31, 8, 9, F_XOR, 0, 0, 0, 1, 0), 0, 1, 0, exp_flags));
        push(mks(1'b0, C_STUR, 3, 4, 6, 8, 1'b0, 5'b0), mke(nopw(2'b00), 0, 1, 0, exp_flags));
        for (int i = 0; sq.size() > 0; i++) begin
            exp_t e;
            apply(sq.pop_front());
            @(posedge clock); #1;
            e = q.pop_front();
            checks++;
            if ({controlWord, K, cmd_ready, halted, flags} !== {e.cw, e.k, e.rdy, e.hlt, e.fl}) begin
                failures++;
                $display("FAIL misc_ops[%0d] got cw=%h k=%0d rdy=%b hlt=%b fl=%b want cw=%h k=%0d rdy=%b hlt=%b fl=%b",
                         i, controlWord, K, cmd_ready, halted, flags, e.cw, e.k, e.rdy, e.hlt, e.fl);
            end
        end
    endtask

    task automatic test_reset_in_ldur();
        exp_t e;
        push(mks(1'b1, C_LDUR, 4, 1, 0, 8, 1'b0, 5'b0),
             mke(mkcw(2'b00, 31, 1, 31, F_ADD, 0, 0, 0, 1, 1), 8, 0, 0, 5'b0));
        q.push_back(mke(nopw(2'b00), 0, 1, 0, 5'b0));
        q.push_back(mke(nopw(2'b00), 0, 1, 0, 5'b0));
        q.push_back(mke(nopw(2'b00), 0, 1, 0, 5'b0));
        exp_flags = 5'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 0) begin
                apply(sq.pop_front());
                @(posedge clock); #1;
            end else if (i == 1) begin
                reset = 1'b0;
                apply(mks(1'b0, C_NOP, 0, 0, 0, 0, 1'b0, 5'b0));
                #2;
            end else if (i == 2) begin
                @(posedge clock); #1;
                reset = 1'b1;
            end else begin
                @(posedge clock); #1;
            end
            e = q.pop_front();
            checks++;
            if ({controlWord, K, cmd_ready, halted, flags} !== {e.cw, e.k, e.rdy, e.hlt, e.fl}) begin
                failures++;
                $display("FAIL reset_in_ldur[%0d] got cw=%h k=%0d rdy=%b hlt=%b fl=%b want cw=%h k=%0d rdy=%b hlt=%b fl=%b",
                         i, controlWord, K, cmd_ready, halted, flags, e.cw, e.k, e.rdy, e.hlt, e.fl);
            end
        end
    endtask

    task automatic test_flags();
        push(mks(1'b1, C_ADD, 1, 2, 3, 0, 1'b1, 5'b01001),
             mke(mkcw(2'b01, 1, 2, 3, F_ADD, 1, 0, 0, 1, 0), 0, 1, 0, exp_flags));
`ifdef CTRL_SEQ_FLAGS_EN
        exp_flags = 5'b01001;
`endif
        push(mks(1'b1, C_ADD, 4, 4, 4, 0, 1'b0, 5'b01001),
             mke(mkcw(2'b01, 4, 4, 4, F_ADD, 1, 0, 0, 1, 0), 0, 1, 0, exp_flags));
        push(mks(1'b1, C_STUR, 2, 2, 2, 1, 1'b1, 5'b10110),
             mke(mkcw(2'b01, 31, 2, 2, F_ADD, 0, 1, 0, 0, 1), 1, 1, 0, exp_flags));
        push(mks(1'b0, C_NOP, 0, 0, 0, 0, 1'b0, 5'b10110), mke(nopw(2'b00), 0, 1, 0, exp_flags));
        push(mks(1'b0, C_NOP, 0, 0, 0, 0, 1'b0, 5'b11111), mke(nopw(2'b00), 0, 1, 0, exp_flags));
        for (int i = 0; sq.size() > 0; i++) begin
            exp_t e;
            apply(sq.pop_front());
            @(posedge clock); #1;
            e = q.pop_front();
            checks++;
            if ({controlWord, K, cmd_ready, halted, flags} !== {e.cw, e.k, e.rdy, e.hlt, e.fl}) begin
                failures++;
                $display("FAIL flags[%0d] got cw=%h k=%0d rdy=%b hlt=%b fl=%b want cw=%h k=%0d rdy=%b hlt=%b fl=%b",
                         i, controlWord, K, cmd_ready, halted, flags, e.cw, e.k, e.rdy, e.hlt, e.fl);
            end
        end
    endtask

    task automatic test_halt();
        push(mks(1'b1, C_HALT, 0, 0, 0, 0, 1'b0, 5'b0), mke(nopw(2'b00), 0, 0, 1, exp_flags));
        for (int n = 0; n < 10; n++)
            push(mks(1'b1, C_ADD, 1, 2, 3, 5, 1'b1, 5'b00110), mke(nopw(2'b00), 0, 0, 1, exp_flags));
        for (int i = 0; sq.size() > 0; i++) begin
            exp_t e;
            apply(sq.pop_front());
            @(posedge clock); #1;
            e = q.pop_front();
            checks++;
            if ({controlWord, K, cmd_ready, halted, flags} !== {e.cw, e.k, e.rdy, e.hlt, e.fl}) begin
                failures++;
                $display("FAIL halt[%0d] got cw=%h k=%0d rdy=%b hlt=%b fl=%b want cw=%h k=%0d rdy=%b hlt=%b fl=%b",
                         i, controlWord, K, cmd_ready, halted, flags, e.cw, e.k, e.rdy, e.hlt, e.fl);
            end
        end
        reset = 1'b0;
        #2;
        checks++;
        if ({halted, cmd_ready, flags} !== {1'b0, 1'b1, 5'b0}) begin
            failures++;
            $display("FAIL halt_exit got hlt=%b rdy=%b fl=%b want hlt=0 rdy=1 fl=00000", halted, cmd_ready, flags);
        end
        reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_back_to_back();
        test_ldur();
        test_misc_ops();
        test_reset_in_ldur();
        test_flags();
        test_halt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
